// File: rtl/ex_unit_pipe_if.sv
// ============================================================================
// ex_unit_pipe_if
// ----------------------------------------------------------------------------
// Purpose : Bundles the issue handshake coming from the reservation station
//           and the result bus going to the CDB arbiter for ex_unit_pipe.
//
// Signal summary
//   Issue side (driven by the reservation station):
//     issue_valid, issue_tag, rs_data, rt_data, pc_1, imm, alu_op,
//     use_imm, sign_ext, br_type, is_jump, is_jr, link
//   Issue side (driven by the execute unit):
//     issue_ready
//   CDB side (driven by the execute unit):
//     cdb_valid, cdb_tag, cdb_data, cdb_ovf, cdb_change_flow, cdb_jb_addr
//   CDB side (driven by the arbiter):
//     cdb_grant
//
// Modports
//   slave  : the execute unit
//   master : the reservation station / arbiter side (or a testbench)
// ============================================================================
interface ex_unit_pipe_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int TAG_W  = 6
);
    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_tag;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] pc_1;
    logic [IMM_W-1:0]  imm;
    logic [3:0]        alu_op;
    logic              use_imm;
    logic              sign_ext;
    logic [2:0]        br_type;
    logic              is_jump;
    logic              is_jr;
    logic              link;

    logic              cdb_valid;
    logic              cdb_grant;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_ovf;
    logic              cdb_change_flow;
    logic [DATA_W-1:0] cdb_jb_addr;

    modport slave (
        input  issue_valid, issue_tag, rs_data, rt_data, pc_1, imm, alu_op,
               use_imm, sign_ext, br_type, is_jump, is_jr, link, cdb_grant,
        output issue_ready, cdb_valid, cdb_tag, cdb_data, cdb_ovf,
               cdb_change_flow, cdb_jb_addr
    );

    modport master (
        output issue_valid, issue_tag, rs_data, rt_data, pc_1, imm, alu_op,
               use_imm, sign_ext, br_type, is_jump, is_jr, link, cdb_grant,
        input  issue_ready, cdb_valid, cdb_tag, cdb_data, cdb_ovf,
               cdb_change_flow, cdb_jb_addr
    );
endinterface

// File: rtl/ex_unit_pipe.sv
// ============================================================================
// ex_unit_pipe
// ----------------------------------------------------------------------------
// Purpose : Registered execute unit between the reservation station and the
//           CDB arbiter. Combines the ALU, the branch/jump resolver and the
//           link-address select, carries the ROB tag with each result, and
//           holds the result in an output register until the arbiter grants.
//           Multiplies take MUL_LAT cycles; everything else takes one.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : kills all in-flight work (result register and pending multiply)
//   ex_if  : ex_unit_pipe_if.slave - issue handshake + operands in,
//            CDB result fields out, cdb_grant in
//
// Parameters
//   DATA_W  : datapath width (>= IMM_W)
//   IMM_W   : immediate field width
//   TAG_W   : ROB tag width
//   MUL_LAT : cycles from multiply issue to result-register load (>= 2)
// ============================================================================
module ex_unit_pipe #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int TAG_W   = 6,
    parameter int MUL_LAT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    ex_unit_pipe_if.slave ex_if
);

    localparam int SH_W   = $clog2(DATA_W);
    localparam int CNT_W  = $clog2(MUL_LAT);
    localparam int LUI_SH = DATA_W - IMM_W;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;
    localparam logic [3:0] OP_LUI = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLTZ = 3'd3;
    localparam logic [2:0] BR_BGEZ = 3'd4;
    localparam logic [2:0] BR_BGTZ = 3'd5;
    localparam logic [2:0] BR_BLEZ = 3'd6;

    localparam logic [DATA_W-1:0] IMM_MASK = DATA_W'({IMM_W{1'b1}});

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
    logic              cdb_ovf_q,   cdb_ovf_d;
    logic              cdb_cf_q,    cdb_cf_d;
    logic [DATA_W-1:0] cdb_jb_q,    cdb_jb_d;

    // Everything a multiply needs at completion is captured at issue, since
    // the reservation station moves on as soon as the op is accepted.
    logic [DATA_W-1:0] mul_a_q;
    logic [DATA_W-1:0] mul_b_q;
    logic [TAG_W-1:0]  mul_tag_q;
    logic              mul_link_q;
    logic [DATA_W-1:0] mul_pc1_q;
    logic              mul_cf_q;
    logic [DATA_W-1:0] mul_jb_q;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic slot_free;
    logic accept;
    logic is_mul;

    assign slot_free         = !cdb_valid_q || ex_if.cdb_grant;
    assign ex_if.issue_ready = rst_n && (state_q == ST_IDLE) && slot_free;
    assign accept            = ex_if.issue_valid && ex_if.issue_ready && !flush;
    assign is_mul            = (ex_if.alu_op == OP_MUL);

    // ------------------------------------------------------------------------
    // Operand B select and immediate extension
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] sext_imm;
    logic [DATA_W-1:0] zext_imm;
    logic [DATA_W-1:0] op_b;
    logic [SH_W-1:0]   shamt;

    assign sext_imm = DATA_W'(signed'(ex_if.imm));
    assign zext_imm = DATA_W'(ex_if.imm);
    assign op_b     = ex_if.use_imm ? (ex_if.sign_ext ? sext_imm : zext_imm)
                                    : ex_if.rt_data;
    assign shamt    = op_b[SH_W-1:0];

    // ------------------------------------------------------------------------
    // Single-cycle ALU. MUL is not produced here; its result comes from the
    // multi-cycle path, so this branch just returns zero.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;

    assign sum  = ex_if.rs_data + op_b;
    assign diff = ex_if.rs_data - op_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (ex_if.alu_op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (ex_if.rs_data[DATA_W-1] == op_b[DATA_W-1]) &&
                          (sum[DATA_W-1] != ex_if.rs_data[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (ex_if.rs_data[DATA_W-1] != op_b[DATA_W-1]) &&
                          (diff[DATA_W-1] != ex_if.rs_data[DATA_W-1]);
            end
            OP_AND: alu_res = ex_if.rs_data & op_b;
            OP_OR:  alu_res = ex_if.rs_data | op_b;
            OP_XOR: alu_res = ex_if.rs_data ^ op_b;
            OP_NOR: alu_res = ~(ex_if.rs_data | op_b);
            OP_SLL: alu_res = ex_if.rs_data << shamt;
            OP_SRL: alu_res = ex_if.rs_data >> shamt;
            OP_SRA: alu_res = DATA_W'($signed(ex_if.rs_data) >>> shamt);
            OP_SLT: alu_res = DATA_W'($signed(ex_if.rs_data) < $signed(op_b));
            OP_LUI: alu_res = zext_imm << LUI_SH;
            OP_MUL: alu_res = '0;
            default: alu_res = op_b;
        endcase
    end

    // ------------------------------------------------------------------------
    // Branch / jump resolution. BEQ/BNE always compare against rt_data, even
    // when use_imm is set, because imm carries the branch offset.
    // ------------------------------------------------------------------------
    logic              rs_neg;
    logic              rs_zero;
    logic              taken;
    logic              change_flow;
    logic [DATA_W-1:0] jb_addr;

    assign rs_neg  = ex_if.rs_data[DATA_W-1];
    assign rs_zero = (ex_if.rs_data == '0);

    always_comb begin
        taken = 1'b0;
        unique case (ex_if.br_type)
            BR_BEQ:  taken = (ex_if.rs_data == ex_if.rt_data);
            BR_BNE:  taken = (ex_if.rs_data != ex_if.rt_data);
            BR_BLTZ: taken = rs_neg;
            BR_BGEZ: taken = !rs_neg;
            BR_BGTZ: taken = !rs_neg && !rs_zero;
            BR_BLEZ: taken = rs_neg || rs_zero;
            default: taken = 1'b0;
        endcase
    end

    assign change_flow = taken || ex_if.is_jump || ex_if.is_jr;

    // The fall-through arm is the pseudo-direct J target; for non-jumping
    // ops it is still registered so the output is deterministic.
    always_comb begin
        if (taken) begin
            jb_addr = ex_if.pc_1 + sext_imm;
        end else if (ex_if.is_jr) begin
            jb_addr = ex_if.rs_data;
        end else begin
            jb_addr = (ex_if.pc_1 & ~IMM_MASK) | zext_imm;
        end
    end

    // ------------------------------------------------------------------------
    // Multiply result. The low DATA_W bits of a two's-complement product are
    // the same whether the operands are treated as signed or unsigned.
    // The operands are held stable in mul_*_q for the whole MUL_LAT window.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] mul_prod;

    assign mul_prod = mul_a_q * mul_b_q;

    // ------------------------------------------------------------------------
    // Next-state logic: FSM, multiply counter and result register.
    // The counter parks at 1 while the result slot is occupied, so a finished
    // multiply waits there until the arbiter frees the slot.
    // ------------------------------------------------------------------------
    logic load_alu;
    logic load_mul;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_alu    = 1'b0;
        load_mul    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = ST_MUL_BUSY;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (slot_free) begin
                        load_mul = 1'b1;
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_ovf_d   = cdb_ovf_q;
        cdb_cf_d    = cdb_cf_q;
        cdb_jb_d    = cdb_jb_q;

        if (load_alu) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = ex_if.issue_tag;
            cdb_data_d  = ex_if.link ? ex_if.pc_1 : alu_res;
            cdb_ovf_d   = ex_if.link ? 1'b0 : alu_ovf;
            cdb_cf_d    = change_flow;
            cdb_jb_d    = jb_addr;
        end else if (load_mul) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = mul_tag_q;
            cdb_data_d  = mul_link_q ? mul_pc1_q : mul_prod;
            cdb_ovf_d   = 1'b0;
            cdb_cf_d    = mul_cf_q;
            cdb_jb_d    = mul_jb_q;
        end else if (ex_if.cdb_grant) begin
            cdb_valid_d = 1'b0;
        end

        // Flush overrides any load or grant and abandons a pending multiply.
        if (flush) begin
            cdb_valid_d = 1'b0;
            state_d     = ST_IDLE;
            cnt_d       = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Control and result registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_ovf_q   <= 1'b0;
            cdb_cf_q    <= 1'b0;
            cdb_jb_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_ovf_q   <= cdb_ovf_d;
            cdb_cf_q    <= cdb_cf_d;
            cdb_jb_q    <= cdb_jb_d;
        end
    end

    // ------------------------------------------------------------------------
    // Multiply capture registers, loaded only when a MUL is accepted.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_tag_q  <= '0;
            mul_link_q <= 1'b0;
            mul_pc1_q  <= '0;
            mul_cf_q   <= 1'b0;
            mul_jb_q   <= '0;
        end else if (accept && is_mul && (state_q == ST_IDLE)) begin
            mul_a_q    <= ex_if.rs_data;
            mul_b_q    <= op_b;
            mul_tag_q  <= ex_if.issue_tag;
            mul_link_q <= ex_if.link;
            mul_pc1_q  <= ex_if.pc_1;
            mul_cf_q   <= change_flow;
            mul_jb_q   <= jb_addr;
        end
    end

    assign ex_if.cdb_valid       = cdb_valid_q;
    assign ex_if.cdb_tag         = cdb_tag_q;
    assign ex_if.cdb_data        = cdb_data_q;
    assign ex_if.cdb_ovf         = cdb_ovf_q;
    assign ex_if.cdb_change_flow = cdb_cf_q;
    assign ex_if.cdb_jb_addr     = cdb_jb_q;

endmodule

// File: doc/ex_unit_pipe.md
Name: ex_unit_pipe

Overview:
- Parametrised, registered execute unit for the out-of-order pipeline, sitting between the reservation station and the CDB arbiter.
- Combines ALU, branch/jump resolver and link-address select.
- Adds over the previous combinational EX stage: ROB-tag carry, valid/ready issue handshake, an output holding register stalled by CDB grant, a multi-cycle multiplier, and flush.

Parameters:
DATA_W, 32, datapath width (>=IMM_W)
IMM_W, 16, immediate field width
TAG_W, 6, ROB tag width
MUL_LAT, 3, multiply latency in cycles from issue to result-register load (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill all in-flight work (mispredict/exception)
issue_valid  in  1  reservation station presents an op
issue_ready  out  1  unit can accept this cycle
issue_tag  in  TAG_W  ROB tag of op
rs_data  in  DATA_W  operand A
rt_data  in  DATA_W  operand B
pc_1  in  DATA_W  PC+1 of op
imm  in  IMM_W  immediate field
alu_op  in  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLL,7 SRL,8 SRA,9 SLT,10 LUI,11 MUL,12-15 PASS_B
use_imm  in  1  operand B = extended imm
sign_ext  in  1  sign- (1) or zero- (0) extend imm
br_type  in  3  0 none,1 BEQ,2 BNE,3 BLTZ,4 BGEZ,5 BGTZ,6 BLEZ,7 none
is_jump  in  1  unconditional J
is_jr  in  1  jump target = rs_data
link  in  1  result = pc_1
cdb_valid  out  1  result register valid
cdb_grant  in  1  arbiter consumes result this cycle
cdb_tag  out  TAG_W  tag of result
cdb_data  out  DATA_W  result
cdb_ovf  out  1  signed overflow (ADD/SUB only)
cdb_change_flow  out  1  branch taken or jump
cdb_jb_addr  out  DATA_W  redirect target

Behaviour:
- Reset (rst_n=0, async): cdb_valid=0, all cdb_* data outputs 0, FSM=IDLE, mul counter 0; issue_ready=0 while rst_n=0.
- Accept = issue_valid & issue_ready & !flush. Ops issued while flush=1 are dropped.
- Slot free = !cdb_valid | cdb_grant.
- issue_ready = (FSM==IDLE) & slot free.
- FSM IDLE: accept of non-MUL loads the result register next edge (latency 1); cdb_valid=1. Accept of MUL -> MUL_BUSY, counter=MUL_LAT-1.
- MUL_BUSY: counter decrements each cycle. When counter reaches 1 and slot free, result loads on that edge -> IDLE. Otherwise counter stops at 1 (MUL_WAIT behaviour) until slot free. Total issue->cdb_valid = MUL_LAT cycles when unstalled.
- cdb_* held stable while cdb_valid=1 and cdb_grant=0. Grant with no new load clears cdb_valid next edge. Grant with simultaneous load: new result replaces it, cdb_valid stays 1.
- flush (sync): next edge cdb_valid=0, FSM=IDLE, multiply discarded; flush wins over grant and load.
- Operand B: use_imm ? ext(imm) to DATA_W : rt_data.
- Shifts use B[$clog2(DATA_W)-1:0]. SRA is arithmetic. LUI = imm << (DATA_W-IMM_W).
- ADD/SUB/MUL wrap mod 2^DATA_W; MUL keeps low DATA_W bits of signed product. SLT is signed, result 1/0.
- cdb_ovf: signed overflow of ADD/SUB only, else 0.
- link=1: cdb_data=pc_1, regardless of alu_op.
- Branch compare: BEQ/BNE compare rs_data with rt_data (not imm); BLTZ..BLEZ test rs_data sign/zero.
- taken = br_type condition true. cdb_change_flow = taken | is_jump | is_jr.
- cdb_jb_addr: taken -> pc_1 + sext(imm); else is_jr -> rs_data; else {pc_1[DATA_W-1:IMM_W], imm}. When none of these apply the value is don't-care, but it is registered deterministically.
- Branch/jump outputs are registered with the result (same latency as ALU ops).

Test Plan:
- ADD rs=0x7FFFFFFF, rt=1, tag 5, cdb_grant=1 -> next cycle cdb_valid=1, cdb_data=0x80000000, cdb_ovf=1, cdb_tag=5.
- MUL rs=-3, rt=7, MUL_LAT=3, grant held 1 -> issue_ready=0 for cycles 1-2, cdb_data=0xFFFFFFEB at cycle 3, issue_ready=1 again.
- BNE rs=4, rt=5, pc_1=0x100, imm=0xFFFE -> cdb_change_flow=1, cdb_jb_addr=0xFE. Same op with rt=4 -> change_flow=0.
- JR+link rs=0x2000, pc_1=0x44 -> cdb_jb_addr=0x2000, cdb_data=0x44, change_flow=1.
- Back-pressure: cdb_grant=0 for 4 cycles after SUB 9-2 -> cdb_data=7 held, issue_ready=0. Grant plus new issue the same cycle -> back-to-back results with no bubble.
- Flush mid-MUL (cycle 1) plus rst_n pulse mid-result -> no cdb_valid for the killed MUL; async reset clears cdb_valid immediately with no clock edge.
